// File: rtl/ccr_unit_if.sv
// ALU-flag / condition-code interface between the execute stage and the CCR.
// Valid/ready note: there is no handshake here; every input is sampled on
// each rising clock edge and the registered outputs are always valid.
interface ccr_unit_if;
  logic       alu_we;
  logic       alu_cf;
  logic       alu_nf;
  logic       alu_zf;
  logic       setc;
  logic       clrc;
  logic [1:0] jmp_type;
  logic       int_save;
  logic       int_restore;
  logic [2:0] ccr_out;
  logic       jmp_taken;
  logic       save_full;
  logic       save_empty;
  logic       stack_err;

  // Execute / interrupt-control side driving flag events.
  modport master (
    output alu_we, alu_cf, alu_nf, alu_zf, setc, clrc, jmp_type,
    output int_save, int_restore,
    input  ccr_out, jmp_taken, save_full, save_empty, stack_err
  );

  // Condition-code register side.
  modport slave (
    input  alu_we, alu_cf, alu_nf, alu_zf, setc, clrc, jmp_type,
    input  int_save, int_restore,
    output ccr_out, jmp_taken, save_full, save_empty, stack_err
  );
endinterface

// File: rtl/ccr_unit.sv
// Condition-code register {CF,NF,ZF} with jump evaluation, SETC/CLRC and a
// small LIFO that saves flags on interrupt entry and restores them on RTI.
module ccr_unit #(
  parameter int SAVE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  ccr_unit_if.slave   bus
);

  localparam int CW = $clog2(SAVE_DEPTH + 1);
  localparam int IW = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(SAVE_DEPTH);

  logic [2:0]    ccr;
  logic [2:0]    stack [SAVE_DEPTH];
  logic [CW-1:0] count;
  logic          full_q;
  logic          empty_q;
  logic          err_q;

  logic [2:0]    base;
  logic [2:0]    computed;
  logic [2:0]    top;
  logic [2:0]    next_ccr;
  logic [CW-1:0] next_count;
  logic          do_push;
  logic          do_pop;
  logic          set_err;
  logic          jmp;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] push_idx;

  assign top_idx  = IW'(count - CW'(1));
  assign push_idx = IW'(count);
  assign top      = stack[top_idx];

  // Jump condition from the registered flags only; bit order {CF,NF,ZF}.
  always_comb begin
    jmp = 1'b0;
    case (bus.jmp_type)
      2'b01:   jmp = ccr[0];
      2'b10:   jmp = ccr[1];
      2'b11:   jmp = ccr[2];
      default: jmp = 1'b0;
    endcase
  end

  // Normal flag path: ALU load, SETC/CLRC override, then clear the tested flag.
  always_comb begin
    base     = bus.alu_we ? {bus.alu_cf, bus.alu_nf, bus.alu_zf} : ccr;
    computed = base;
    if (bus.setc)      computed[2] = 1'b1;
    else if (bus.clrc) computed[2] = 1'b0;
    if (jmp) begin
      case (bus.jmp_type)
        2'b01:   computed[0] = 1'b0;
        2'b10:   computed[1] = 1'b0;
        2'b11:   computed[2] = 1'b0;
        default: computed    = computed;
      endcase
    end
  end

  // LIFO control and next CCR selection; a restore with data overrides everything.
  always_comb begin
    next_ccr   = computed;
    next_count = count;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    set_err    = 1'b0;
    if (bus.int_save && bus.int_restore) begin
      // Conflicting request: peek the top without popping, flag misuse.
      set_err = 1'b1;
      if (!empty_q) next_ccr = top;
    end else if (bus.int_restore) begin
      if (!empty_q) begin
        next_ccr   = top;
        do_pop     = 1'b1;
        next_count = count - CW'(1);
      end else begin
        set_err = 1'b1;
      end
    end else if (bus.int_save) begin
      if (!full_q) begin
        do_push    = 1'b1;
        next_count = count + CW'(1);
      end else begin
        set_err = 1'b1;
      end
    end
  end

  // Flag register, LIFO counter and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr     <= 3'b000;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      ccr     <= next_ccr;
      count   <= next_count;
      full_q  <= (next_count == DEPTH_C);
      empty_q <= (next_count == '0);
      if (set_err) err_q <= 1'b1;
    end
  end

  // LIFO storage; pushed value is the flags being written this same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SAVE_DEPTH; i++) stack[i] <= 3'b000;
    end else if (do_push) begin
      stack[push_idx] <= computed;
    end
  end

  assign bus.ccr_out    = ccr;
  assign bus.jmp_taken  = jmp;
  assign bus.save_full  = full_q;
  assign bus.save_empty = empty_q;
  assign bus.stack_err  = err_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Bench for ccr_unit: directed scenarios followed by random traffic, all
// checked against a flag/stack reference model kept in this file.
module tb_ccr_unit;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ccr_unit_if bus();

  ccr_unit #(.SAVE_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: named flags and a queue used as the LIFO.
  logic       m_cf, m_nf, m_zf;
  logic [2:0] exp_q[$];
  logic       m_err;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".ccr"},   bus.ccr_out, {m_cf, m_nf, m_zf});
    check({tag, ".full"},  {2'b00, bus.save_full},  {2'b00, exp_q.size() == DEPTH});
    check({tag, ".empty"}, {2'b00, bus.save_empty}, {2'b00, exp_q.size() == 0});
    check({tag, ".err"},   {2'b00, bus.stack_err},  {2'b00, m_err});
  endtask

  task automatic idle_inputs();
    bus.alu_we = 0; bus.alu_cf = 0; bus.alu_nf = 0; bus.alu_zf = 0;
    bus.setc = 0; bus.clrc = 0; bus.jmp_type = 2'b00;
    bus.int_save = 0; bus.int_restore = 0;
  endtask

  // Reset asserted between edges; outputs must clear with no clock edge.
  task automatic do_reset(input string tag);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    m_cf = 0; m_nf = 0; m_zf = 0; m_err = 0;
    exp_q.delete();
    check_state({tag, ".rst"});
    check({tag, ".rst_jmp"}, {2'b00, bus.jmp_taken}, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Driver task: applies one cycle of inputs and checks both the same-cycle
  // jump result and the registered outcome after the edge.
  task automatic step(input string tag, input logic we, input logic [2:0] f,
                      input logic sc, input logic cc, input logic [1:0] jt,
                      input logic sv, input logic rs);
    logic take;
    logic cf, nf, zf;
    logic [2:0] nxt;
    bus.alu_we = we; {bus.alu_cf, bus.alu_nf, bus.alu_zf} = f;
    bus.setc = sc; bus.clrc = cc; bus.jmp_type = jt;
    bus.int_save = sv; bus.int_restore = rs;
    #1;
    take = (jt == 2'd1 && m_zf) || (jt == 2'd2 && m_nf) || (jt == 2'd3 && m_cf);
    check({tag, ".jmp"}, {2'b00, bus.jmp_taken}, {2'b00, take});
    // Ordinary update of the flags.
    if (we) {cf, nf, zf} = f; else {cf, nf, zf} = {m_cf, m_nf, m_zf};
    if (sc) cf = 1; else if (cc) cf = 0;
    if (take && jt == 2'd1) zf = 0;
    if (take && jt == 2'd2) nf = 0;
    if (take && jt == 2'd3) cf = 0;
    nxt = {cf, nf, zf};
    if (sv && rs) begin
      m_err = 1;
      if (exp_q.size() > 0) nxt = exp_q[$];
    end else if (rs) begin
      if (exp_q.size() > 0) nxt = exp_q.pop_back();
      else m_err = 1;
    end else if (sv) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(nxt);
      else m_err = 1;
    end
    @(posedge clk);
    #1;
    {m_cf, m_nf, m_zf} = nxt;
    check_state(tag);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    do_reset("r0");

    // Flag load then hold.
    step("load101", 1, 3'b101, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) step("hold", 0, 3'b000, 0, 0, 2'b00, 0, 0);
    check("hold_const", bus.ccr_out, 3'b101);

    // JZ taken clears ZF, repeat not taken.
    step("load001", 1, 3'b001, 0, 0, 2'b00, 0, 0);
    step("jz1", 0, 3'b000, 0, 0, 2'b01, 0, 0);
    check("jz_clear", bus.ccr_out, 3'b000);
    step("jz2", 0, 3'b000, 0, 0, 2'b01, 0, 0);

    // JC with simultaneous ALU write.
    step("load100", 1, 3'b100, 0, 0, 2'b00, 0, 0);
    step("jc_alu", 1, 3'b110, 0, 0, 2'b11, 0, 0);
    check("jc_alu_val", bus.ccr_out, 3'b010);

    // Nesting.
    do_reset("r1");
    step("push010", 1, 3'b010, 0, 0, 2'b00, 1, 0);
    step("push101", 1, 3'b101, 0, 0, 2'b00, 1, 0);
    check("full_const", {2'b00, bus.save_full}, 3'b001);
    step("push_ovf", 0, 3'b000, 0, 0, 2'b00, 1, 0);
    step("alu000", 1, 3'b000, 0, 0, 2'b00, 0, 0);
    step("pop1", 1, 3'b111, 1, 0, 2'b00, 0, 1);
    check("pop1_val", bus.ccr_out, 3'b101);
    step("pop2", 0, 3'b000, 0, 0, 2'b00, 0, 1);
    check("pop2_val", bus.ccr_out, 3'b010);
    step("pop_unf", 0, 3'b000, 0, 0, 2'b00, 0, 1);

    // Simultaneous save/restore on a non-empty stack.
    do_reset("r2");
    step("push110", 1, 3'b110, 0, 0, 2'b00, 1, 0);
    step("alu001", 1, 3'b001, 0, 0, 2'b00, 0, 0);
    step("both", 1, 3'b111, 0, 0, 2'b00, 1, 1);
    step("pop_after_both", 0, 3'b000, 0, 0, 2'b00, 0, 1);

    // SETC/CLRC.
    do_reset("r3");
    step("setc_clrc", 0, 3'b000, 1, 1, 2'b00, 0, 0);
    check("setc_wins", bus.ccr_out, 3'b100);
    step("clrc_alu", 1, 3'b111, 0, 1, 2'b00, 0, 0);
    check("clrc_alu_val", bus.ccr_out, 3'b011);

    // Random traffic with occasional mid-sequence resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd",
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
             2'($urandom_range(0, 3)),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
